// File: rtl/xor_bank_buffer_if.sv
// xor_bank_buffer_if: keystream, raw-store and result ports of the banked XOR buffer.
interface xor_bank_buffer_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 10,
   parameter int LW     = 5
);
   logic              iflush;
   logic              iks_valid;
   logic [DATA_W-1:0] iks_data;
   logic              oks_ready;
   logic [ADDR_W-1:0] iaddr;
   logic              iraw_write_en;
   logic [DATA_W-1:0] iraw_wdata;
   logic              ird_en;
   logic              imode;
   logic              irelease;
   logic [DATA_W-1:0] ordata;
   logic              ordata_valid;
   logic              obank_ready;
   logic [LW-1:0]     olevel;
   modport master (
      output iflush, iks_valid, iks_data, iaddr, iraw_write_en, iraw_wdata, ird_en, imode, irelease,
      input  oks_ready, ordata, ordata_valid, obank_ready, olevel
   );
   modport slave (
      input  iflush, iks_valid, iks_data, iaddr, iraw_write_en, iraw_wdata, ird_en, imode, irelease,
      output oks_ready, ordata, ordata_valid, obank_ready, olevel
   );
endinterface

// File: rtl/xor_bank_buffer.sv
// xor_bank_buffer: ring of banks filled with keystream, consumed as raw ^ keystream.
module xor_bank_buffer #(
   parameter int RAM_BLOCKS = 16,
   parameter int DATA_W     = 4,
   parameter int ADDR_W     = 10
) (
   input logic               iclk,
   input logic               irst,
   xor_bank_buffer_if.slave  bus
);
   localparam int BW    = $clog2(RAM_BLOCKS);
   localparam int LW    = BW + 1;
   localparam int DEPTH = RAM_BLOCKS << ADDR_W;
   logic [DATA_W-1:0] ks_mem  [DEPTH];
   logic [DATA_W-1:0] raw_mem [DEPTH];
   logic [BW-1:0]     wp_q, wp_d, rp_q, rp_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [LW-1:0]     level_q, level_d;
   logic              bank_ready_q;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q;
   logic              ks_acc, done, rel, rd;
   logic [DATA_W-1:0] raw_word, result;
   assign bus.oks_ready    = (level_q < LW'(RAM_BLOCKS)) & ~irst & ~bus.iflush;
   assign bus.ordata       = rdata_q;
   assign bus.ordata_valid = rvalid_q;
   assign bus.obank_ready  = bank_ready_q;
   assign bus.olevel       = level_q;
   assign ks_acc = bus.iks_valid & bus.oks_ready;
   assign done   = ks_acc & (&waddr_q);
   assign rel    = bus.irelease & bank_ready_q & ~bus.iflush;
   assign rd     = bus.ird_en & bank_ready_q & ~bus.iflush;
   always_comb begin
      raw_word = raw_mem[{rp_q, bus.iaddr}];
      result   = bus.imode ? raw_word : raw_word ^ ks_mem[{rp_q, bus.iaddr}];
      rdata_d  = rd ? result : rdata_q;
      wp_d     = bus.iflush ? '0 : wp_q + BW'(done);
      rp_d     = bus.iflush ? '0 : rp_q + BW'(rel);
      waddr_d  = bus.iflush ? '0 : waddr_q + ADDR_W'(ks_acc);
      level_d  = bus.iflush ? '0 : level_q + LW'(done) - LW'(rel);
   end
   always_ff @(posedge iclk) begin
      if (irst) begin
         wp_q         <= '0;
         rp_q         <= '0;
         waddr_q      <= '0;
         level_q      <= '0;
         bank_ready_q <= 1'b0;
         rdata_q      <= '0;
         rvalid_q     <= 1'b0;
      end else begin
         wp_q         <= wp_d;
         rp_q         <= rp_d;
         waddr_q      <= waddr_d;
         level_q      <= level_d;
         bank_ready_q <= level_d != '0;
         rdata_q      <= rdata_d;
         rvalid_q     <= rd;
      end
   end
   // Storage carries no reset; nonblocking writes give read-first behaviour.
   always_ff @(posedge iclk) begin
      if (ks_acc) ks_mem[{wp_q, waddr_q}] <= bus.iks_data;
      if (bus.iraw_write_en & ~bus.iflush & ~irst) raw_mem[{rp_q, bus.iaddr}] <= bus.iraw_wdata;
   end
endmodule
